// File: rtl/cpu_alu_seq.sv
// Multi-cycle ALU: steps a SLICE_W-bit datapath LSB-first over DATA_W-bit
// operands, chaining carry/borrow and the zero condition across slices.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | processing one slice per clock
// DONE  | one-cycle result pulse; start here chains straight into RUN
module cpu_alu_seq #(
  parameter int DATA_W  = 16,
  parameter int SLICE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [7:0]        flags_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] res,
  output logic [7:0]        flags
);

  localparam int NSLICE = DATA_W / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);
  localparam int MSB  = DATA_W - 1;
  localparam int HBIT = DATA_W - 4;  // carry into this bit = carry out of bit DATA_W-5

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_CP  = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               load, step, last;
  logic [2:0]         op_q;
  logic [DATA_W-1:0]  a_q, b_q, acc_q;
  logic               carry_q, zacc_q;
  logic [IDX_W-1:0]   idx_q;

  // Only the carry bit of the incoming flag register is consumed.
  logic flags_in_unused;
  assign flags_in_unused = ^flags_in[7:1];

  // Subtract-type ops run as a + ~b + ~borrow; carry_q holds the raw adder carry.
  logic is_sub_in, cin_in;
  assign is_sub_in = (op == OP_SUB) || (op == OP_SBC) || (op == OP_CP);
  assign cin_in    = ((op == OP_ADC) || (op == OP_SBC)) ? flags_in[0] : 1'b0;

  logic is_sub, is_logic;
  assign is_sub   = (op_q == OP_SUB) || (op_q == OP_SBC) || (op_q == OP_CP);
  assign is_logic = (op_q == OP_AND) || (op_q == OP_OR) || (op_q == OP_XOR);
  assign last     = (idx_q == LAST_IDX);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) state_d = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          load    = 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Slice datapath and flag generation for the slice selected by idx_q.
  logic [SLICE_W-1:0] a_s, b_s, b_eff_s, slice_res;
  logic [SLICE_W:0]   sum_ext;
  logic [DATA_W-1:0]  full_res, res_d;
  logic               zacc_d, b_h, b_m, carry_h, ovf, cout;
  logic [7:0]         flags_d;

  always_comb begin
    a_s       = a_q[idx_q*SLICE_W +: SLICE_W];
    b_s       = b_q[idx_q*SLICE_W +: SLICE_W];
    b_eff_s   = is_sub ? ~b_s : b_s;
    sum_ext   = {1'b0, a_s} + {1'b0, b_eff_s} + {{SLICE_W{1'b0}}, carry_q};
    case (op_q)
      OP_AND:  slice_res = a_s & b_s;
      OP_OR:   slice_res = a_s | b_s;
      OP_XOR:  slice_res = a_s ^ b_s;
      default: slice_res = sum_ext[SLICE_W-1:0];
    endcase
    cout      = sum_ext[SLICE_W];
    zacc_d    = zacc_q & (slice_res == '0);
    full_res  = acc_q;
    full_res[idx_q*SLICE_W +: SLICE_W] = slice_res;
    // Carry into any bit of a full-width sum is a ^ b ^ sum at that bit.
    b_h       = is_sub ? ~b_q[HBIT] : b_q[HBIT];
    b_m       = is_sub ? ~b_q[MSB]  : b_q[MSB];
    carry_h   = a_q[HBIT] ^ b_h ^ full_res[HBIT];
    ovf       = (a_q[MSB] == b_m) && (full_res[MSB] != a_q[MSB]);
    flags_d   = 8'h00;
    flags_d[7] = full_res[MSB];
    flags_d[6] = zacc_d;
    flags_d[4] = is_logic ? (op_q == OP_AND) : (is_sub ? ~carry_h : carry_h);
    flags_d[2] = is_logic ? ~^full_res : ovf;
    flags_d[1] = is_sub;
    flags_d[0] = is_logic ? 1'b0 : (is_sub ? ~cout : cout);
    res_d     = (op_q == OP_CP) ? a_q : full_res;
  end

  // Operand capture, slice stepping and result/flag write on the last slice.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b1;
      idx_q   <= '0;
      res     <= '0;
      flags   <= 8'h00;
    end else if (load) begin
      op_q    <= op;
      a_q     <= op_a;
      b_q     <= op_b;
      acc_q   <= '0;
      carry_q <= is_sub_in ? ~cin_in : cin_in;
      zacc_q  <= 1'b1;
      idx_q   <= '0;
    end else if (step) begin
      acc_q   <= full_res;
      carry_q <= cout;
      zacc_q  <= zacc_d;
      if (last) begin
        res   <= res_d;
        flags <= flags_d;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_alu_seq.sv
// Scoreboard bench for cpu_alu_seq at DATA_W=16 and DATA_W=32.
module tb_cpu_alu_seq;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start16, start32;
  logic [2:0]  op;
  logic [15:0] a16, b16;
  logic [31:0] a32, b32;
  logic [7:0]  flags_in;
  logic        busy16, done16, busy32, done32;
  logic [15:0] res16;
  logic [31:0] res32;
  logic [7:0]  flags16, flags32;

  cpu_alu_seq #(.DATA_W(16), .SLICE_W(8)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .op(op), .op_a(a16), .op_b(b16),
    .flags_in(flags_in), .busy(busy16), .done(done16), .res(res16), .flags(flags16)
  );

  cpu_alu_seq #(.DATA_W(32), .SLICE_W(8)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .op(op), .op_a(a32), .op_b(b32),
    .flags_in(flags_in), .busy(busy32), .done(done32), .res(res32), .flags(flags32)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [7:0]  flags;
    int          cyc;
  } exp_t;

  exp_t q16[$];
  exp_t q32[$];
  exp_t e16, e32;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [15:0] a, b;
    logic [7:0]  fin;
    logic [15:0] res;
    logic [7:0]  flags;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  // Monitor for the 16-bit instance.
  always @(negedge clk) begin
    if (done16) begin
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done16_unexpected actual=done expected=no_done at cycle %0d", cyc);
      end else begin
        e16 = q16.pop_front();
        chk("res16", {16'h0, res16}, e16.res);
        chk("flags16", {24'h0, flags16}, {24'h0, e16.flags});
        chk("done16_cycle", cyc, e16.cyc);
        chk("busy16_in_done", {31'h0, busy16}, 32'h0);
      end
    end
  end

  // Monitor for the 32-bit instance.
  always @(negedge clk) begin
    if (done32) begin
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done32_unexpected actual=done expected=no_done at cycle %0d", cyc);
      end else begin
        e32 = q32.pop_front();
        chk("res32", res32, e32.res);
        chk("flags32", {24'h0, flags32}, {24'h0, e32.flags});
        chk("done32_cycle", cyc, e32.cyc);
      end
    end
  end

  // Called at a negedge: drive a start for the next edge and queue the expectation.
  task automatic issue16(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [7:0] fin, input logic [15:0] er, input logic [7:0] ef);
    exp_t x;
    op       = o;
    a16      = a;
    b16      = b;
    flags_in = fin;
    start16  = 1'b1;
    x.res    = {16'h0, er};
    x.flags  = ef;
    x.cyc    = cyc + 3;
    q16.push_back(x);
  endtask

  task automatic scramble();
    start16  = 1'b0;
    a16      = 16'($urandom);
    b16      = 16'($urandom);
    op       = 3'($urandom);
    flags_in = 8'($urandom);
  endtask

  task automatic wait_done16();
    bit seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (done16) seen = 1'b1;
      else chk("busy16_run", {31'h0, busy16}, 32'h1);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done16_timeout actual=no_done expected=done");
    end
  endtask

  task automatic run16(input vec_t v);
    @(negedge clk);
    chk("busy16_idle", {31'h0, busy16}, 32'h0);
    issue16(v.op, v.a, v.b, v.fin, v.res, v.flags);
    @(negedge clk);
    scramble();
    chk("busy16_after_start", {31'h0, busy16}, 32'h1);
    wait_done16();
  endtask

  initial begin
    int ndone;
    bit seen;
    exp_t x;

    vecs[0]  = '{"add_h",      3'd0, 16'h0FFF, 16'h0001, 8'h00, 16'h1000, 8'h10};
    vecs[1]  = '{"add_ovf",    3'd0, 16'h7FFF, 16'h0001, 8'h00, 16'h8000, 8'h94};
    vecs[2]  = '{"sub_h",      3'd2, 16'h1000, 16'h0001, 8'h00, 16'h0FFF, 8'h12};
    vecs[3]  = '{"sbc_cin",    3'd3, 16'h0000, 16'h0000, 8'h01, 16'hFFFF, 8'h93};
    vecs[4]  = '{"adc_cin",    3'd1, 16'hFFFF, 16'h0000, 8'h01, 16'h0000, 8'h51};
    vecs[5]  = '{"and_zchain", 3'd4, 16'hFF00, 16'h0F00, 8'h00, 16'h0F00, 8'h14};
    vecs[6]  = '{"xor_par",    3'd6, 16'h00FF, 16'h0000, 8'h00, 16'h00FF, 8'h04};
    vecs[7]  = '{"cp_eq",      3'd7, 16'h1234, 16'h1234, 8'h00, 16'h1234, 8'h42};
    vecs[8]  = '{"cp_lt",      3'd7, 16'h0001, 16'h0002, 8'h00, 16'h0001, 8'h93};
    vecs[9]  = '{"or_zero",    3'd5, 16'h0000, 16'h0000, 8'h01, 16'h0000, 8'h44};
    vecs[10] = '{"add_no_cin", 3'd0, 16'hFFFF, 16'h0001, 8'h01, 16'h0000, 8'h51};

    reset = 1'b1; start16 = 1'b0; start32 = 1'b0; op = 3'd0;
    a16 = '0; b16 = '0; a32 = '0; b32 = '0; flags_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy16",  {31'h0, busy16}, 32'h0);
    chk("rst_done16",  {31'h0, done16}, 32'h0);
    chk("rst_res16",   {16'h0, res16}, 32'h0);
    chk("rst_flags16", {24'h0, flags16}, 32'h0);
    chk("rst_busy32",  {31'h0, busy32}, 32'h0);
    chk("rst_res32",   res32, 32'h0);

    foreach (vecs[i]) run16(vecs[i]);

    // Start pulsed while busy must be ignored.
    @(negedge clk);
    issue16(3'd0, 16'h0001, 16'h0001, 8'h00, 16'h0002, 8'h00);
    @(negedge clk);
    op = 3'd5; a16 = 16'hFFFF; b16 = 16'h0000; start16 = 1'b1;
    @(negedge clk);
    scramble();
    wait_done16();
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (done16) ndone++;
    end
    chk("ignored_start_no_extra_done", ndone, 0);

    // Back-to-back: second start issued in the DONE cycle.
    @(negedge clk);
    issue16(3'd0, 16'h1111, 16'h2222, 8'h00, 16'h3333, 8'h00);
    @(negedge clk);
    scramble();
    wait_done16();
    issue16(3'd2, 16'h0005, 16'h0003, 8'h00, 16'h0002, 8'h02);
    @(negedge clk);
    scramble();
    chk("b2b_busy16", {31'h0, busy16}, 32'h1);
    wait_done16();

    // Reset during RUN aborts with no done and clears outputs.
    @(negedge clk);
    op = 3'd0; a16 = 16'h0101; b16 = 16'h0101; flags_in = 8'h00; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    chk("abort_busy_before", {31'h0, busy16}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy",  {31'h0, busy16}, 32'h0);
    chk("abort_done",  {31'h0, done16}, 32'h0);
    chk("abort_res",   {16'h0, res16}, 32'h0);
    chk("abort_flags", {24'h0, flags16}, 32'h0);
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (done16) ndone++;
    end
    chk("abort_no_done", ndone, 0);

    // 32-bit instance: latency 4.
    @(negedge clk);
    op = 3'd0; a32 = 32'h7FFF_FFFF; b32 = 32'h0000_0001; flags_in = 8'h00; start32 = 1'b1;
    x.res = 32'h8000_0000; x.flags = 8'h94; x.cyc = cyc + 5;
    q32.push_back(x);
    @(negedge clk);
    start32 = 1'b0; a32 = 32'($urandom); b32 = 32'($urandom);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (done32) seen = 1'b1;
      else chk("busy32_run", {31'h0, busy32}, 32'h1);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done32_timeout actual=no_done expected=done");
    end

    repeat (3) @(negedge clk);
    chk("q16_drained", q16.size(), 0);
    chk("q32_drained", q32.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
